// File: rtl/column_1_norm.sv
// Signed Euclidean norm of matrix column 1: sign(a11)*sqrt(a11^2 + a21^2), bit-serial root.
// Optional build macro COLUMN_1_NORM_ROUND_EN selects round-to-nearest instead of floor.
module column_1_norm (
  input  logic        I_sys_clk,
  input  logic        I_sys_rstn,
  input  logic        I_column_1_norm_ena,
  input  logic        I_column_1_norm_start,
  input  logic [15:0] I_a11,
  input  logic [15:0] I_a21,
  output logic        O_busy,
  output logic        O_column_1_amp_valid,
  output logic [16:0] O_column_1_amp,
  output logic [15:0] O_a11,
  output logic [15:0] O_a21,
  output logic [1:0]  O_dbg_state
);

  // Handshake: start is accepted on an enabled edge while IDLE; O_column_1_amp_valid
  // is a single-cycle pulse on which O_column_1_amp/O_a11/O_a21 are all current.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SQUARE = 2'd1,
    S_ROOT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_abs11;
  logic [15:0] r_abs21;
  logic [31:0] r_s;
  logic [15:0] r_root;
  logic [19:0] r_rem;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_valid;
  logic [16:0] r_amp;
  logic [15:0] r_a11;
  logic [15:0] r_a21;

  logic [15:0] w_abs11;
  logic [15:0] w_abs21;
  logic [31:0] w_sq;
  logic [19:0] w_rem_sh;
  logic [19:0] w_qterm;
  logic [19:0] w_rem_nxt;
  logic [16:0] w_mag;
  logic [16:0] w_amp;

  assign w_abs11 = I_a11[15] ? (~I_a11 + 16'd1) : I_a11;
  assign w_abs21 = I_a21[15] ? (~I_a21 + 16'd1) : I_a21;
  assign w_sq    = ({16'd0, r_abs11} * {16'd0, r_abs11}) + ({16'd0, r_abs21} * {16'd0, r_abs21});

  // Non-restoring step: subtract 4Q+1 on a non-negative remainder, add 4Q+3 on a negative one.
  assign w_rem_sh  = {r_rem[17:0], r_s[31:30]};
  assign w_qterm   = {2'b00, r_root, r_rem[19], 1'b1};
  assign w_rem_nxt = r_rem[19] ? (w_rem_sh + w_qterm) : (w_rem_sh - w_qterm);

`ifdef COLUMN_1_NORM_ROUND_EN
  logic [19:0] w_rem_fix;
  logic        w_round;
  // A negative final remainder is restored before comparing S - r^2 against r.
  assign w_rem_fix = r_rem[19] ? (r_rem + {3'b000, r_root, 1'b1}) : r_rem;
  assign w_round   = $signed(w_rem_fix) > $signed({4'b0000, r_root});
  assign w_mag     = {1'b0, r_root} + {16'd0, w_round};
`else
  assign w_mag     = {1'b0, r_root};
`endif

  assign w_amp = r_a11[15] ? (~w_mag + 17'd1) : w_mag;

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      r_state <= S_IDLE;
      r_abs11 <= '0;
      r_abs21 <= '0;
      r_s     <= '0;
      r_root  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_amp   <= '0;
      r_a11   <= '0;
      r_a21   <= '0;
    end else begin
      // Valid is never stretched by a disabled cycle.
      r_valid <= 1'b0;
      if (I_column_1_norm_ena) begin
        case (r_state)
          S_IDLE: begin
            if (I_column_1_norm_start) begin
              r_a11   <= I_a11;
              r_a21   <= I_a21;
              r_abs11 <= w_abs11;
              r_abs21 <= w_abs21;
              r_busy  <= 1'b1;
              r_state <= S_SQUARE;
            end
          end
          S_SQUARE: begin
            r_s     <= w_sq;
            r_root  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= S_ROOT;
          end
          S_ROOT: begin
            r_s    <= {r_s[29:0], 2'b00};
            r_rem  <= w_rem_nxt;
            r_root <= {r_root[14:0], ~w_rem_nxt[19]};
            r_cnt  <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_state <= S_DONE;
            end
          end
          S_DONE: begin
            r_amp   <= w_amp;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign O_busy               = r_busy;
  assign O_column_1_amp_valid = r_valid;
  assign O_column_1_amp       = r_amp;
  assign O_a11                = r_a11;
  assign O_a21                = r_a21;
  assign O_dbg_state          = r_state;

endmodule

// File: tb/tb_column_1_norm.sv
// Bench for column_1_norm: table vectors, random operands against a floor-sqrt model,
// and hand-written sequences for start re-pulse, enable stall and mid-operation reset.
module tb_column_1_norm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [15:0] a11;
  logic [15:0] a21;
  logic        busy;
  logic        valid;
  logic [16:0] amp;
  logic [15:0] o_a11;
  logic [15:0] o_a21;
  logic [1:0]  dbg_state;

  column_1_norm dut (
    .I_sys_clk            (clk),
    .I_sys_rstn           (rst_n),
    .I_column_1_norm_ena  (ena),
    .I_column_1_norm_start(start),
    .I_a11                (a11),
    .I_a21                (a21),
    .O_busy               (busy),
    .O_column_1_amp_valid (valid),
    .O_column_1_amp       (amp),
    .O_a11                (o_a11),
    .O_a21                (o_a21),
    .O_dbg_state          (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic prev_valid = 1'b0;
  logic [48:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model_amp(input logic [15:0] x, input logic [15:0] y);
    longint sx, sy, s, r, t;
    logic [16:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s = sx * sx + sy * sy;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= s) r = t;
    end
`ifdef COLUMN_1_NORM_ROUND_EN
    if (s - r * r > r) r = r + 1;
`endif
    if (sx < 0) r = -r;
    res = r[16:0];
    return res;
  endfunction

  // scoreboard: compare every valid pulse against the oldest expectation
  always @(negedge clk) begin
    logic [48:0] e;
    if (valid) begin
      pulses++;
      chk("valid_width", {63'd0, prev_valid}, 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got amp=%0h want no pulse", amp);
      end else begin
        e = exp_q.pop_front();
        chk("amp", {47'd0, amp}, {47'd0, e[48:32]});
        chk("o_a11", {48'd0, o_a11}, {48'd0, e[31:16]});
        chk("o_a21", {48'd0, o_a21}, {48'd0, e[15:0]});
      end
    end
    prev_valid = valid;
  end

  // driver: one operation, with optional start re-pulses and an enable stall
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic [16:0] e,
                       input int repulse, input int ena_drop, input int exp_lat);
    int n;
    int nb;
    a11 = x;
    a21 = y;
    start = 1'b1;
    exp_q.push_back({e, x, y});
    @(posedge clk);
    #1;
    start = 1'b0;
    a11 = 16'($urandom);
    a21 = 16'($urandom);
    nb = busy ? 1 : 0;
    n = 0;
    while (!valid && n < 60) begin
      if (repulse != 0 && (n == 5 || n == 10)) begin
        start = 1'b1;
        a11 = 16'd100;
        a21 = 16'd200;
      end else begin
        start = 1'b0;
      end
      if (ena_drop > 0 && n == ena_drop) ena = 1'b0;
      if (ena_drop > 0 && n == ena_drop + 4) ena = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (busy) nb++;
    end
    start = 1'b0;
    ena = 1'b1;
    chk("latency", 64'(n), 64'(exp_lat));
    chk("busy_cycles", 64'(nb), 64'(exp_lat));
    if (!valid && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_valid"}, {63'd0, valid}, 64'd0);
    chk({tag, "_amp"}, {47'd0, amp}, 64'd0);
    chk({tag, "_a11"}, {48'd0, o_a11}, 64'd0);
    chk({tag, "_a21"}, {48'd0, o_a21}, 64'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] amp;
  } vec_t;

  vec_t vt[10];

  initial begin
    int p0;
    logic [15:0] rx;
    logic [15:0] ry;

    vt[0] = '{16'd3,      16'd4,      17'd5};
    vt[1] = '{16'hFFFD,   16'd4,      17'h1FFFB};
    vt[2] = '{16'd0,      16'hFFF9,   17'd7};
`ifdef COLUMN_1_NORM_ROUND_EN
    vt[3] = '{16'h8000,   16'h8000,   17'h14AFB};
    vt[5] = '{16'd2,      16'd3,      17'd4};
`else
    vt[3] = '{16'h8000,   16'h8000,   17'h14AFC};
    vt[5] = '{16'd2,      16'd3,      17'd3};
`endif
    vt[4] = '{16'd1,      16'd1,      17'd1};
    vt[6] = '{16'd5,      16'd5,      17'd7};
    vt[7] = '{16'd32767,  16'd0,      17'd32767};
    vt[8] = '{16'hFFFF,   16'd0,      17'h1FFFF};
    vt[9] = '{16'd0,      16'd0,      17'd0};

    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    a11 = '0;
    a21 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_zero_outputs("after_reset");

    // back-to-back: each start is driven in the cycle the previous valid is high
    for (int i = 0; i < 10; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].amp, 0, 0, 18);
    end
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom_range(0, 65535));
      ry = 16'($urandom_range(0, 65535));
      do_op(rx, ry, model_amp(rx, ry), 0, 0, 18);
    end
    repeat (3) @(posedge clk);
    #1;

    // start re-pulsed mid-operation is ignored
    p0 = pulses;
    do_op(16'd3, 16'd4, 17'd5, 1, 0, 18);
    repeat (25) @(posedge clk);
    #1;
    chk("repulse_pulses", 64'(pulses - p0), 64'd1);

    // enable low for 4 cycles inside ROOT
    do_op(16'hFFFD, 16'd4, 17'h1FFFB, 0, 6, 22);
    repeat (3) @(posedge clk);
    #1;

    // reset at cycle 9 of an operation
    a11 = 16'd9;
    a21 = 16'd12;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    p0 = pulses;
    #3;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("reset_no_pulse", 64'(pulses - p0), 64'd0);
    do_op(16'd9, 16'd12, 17'd15, 0, 0, 18);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
